// File: rtl/track_line_fetch_if.sv
// Track ROM read port: one outstanding request at a time, retired by a
// single-cycle acknowledge that also qualifies the returned word.
interface track_line_fetch_if #(
    parameter int unsigned ADDR_W = 13
);
    logic              rom_req;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_ack;
    logic [31:0]       rom_data;

    modport master (output rom_req, output rom_addr, input rom_ack, input rom_data);
    modport slave  (input rom_req, input rom_addr, output rom_ack, output rom_data);
endinterface

// File: rtl/track_line_fetch.sv
// Per-scanline track row fetch into a ping-pong line buffer, with a registered
// 4x horizontally scaled palette-index read-out driven by DrawX/DrawY.
module track_line_fetch #(
    parameter int unsigned ROW_WORDS   = 20,
    parameter int unsigned TRACK_ROWS  = 240,
    parameter int unsigned ACTIVE_ROWS = 240,
    parameter int unsigned ADDR_W      = 13
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               hs,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic [7:0]         line,
    track_line_fetch_if.master rom,
    output logic [3:0]         pixel,
    output logic               busy,
    output logic               underrun
);
    localparam int unsigned WW = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;

    typedef enum logic [2:0] {IDLE, ARM, REQ, WAIT, DRAIN} state_t;
    state_t state, state_next;

    logic          hs_d;
    logic          hs_fall;
    logic          front_sel;
    logic          back_sel;
    logic          front_valid;
    logic          back_valid;
    logic [7:0]    line_q;
    logic [WW-1:0] word;
    logic          word_last;
    logic          line_bad;
    logic          buf_we;

    logic [31:0]   bank [2][ROW_WORDS];

    logic [7:0]    px;
    logic [4:0]    wsel;
    logic [2:0]    nib;
    logic          in_view;
    logic [WW-1:0] rd_idx;
    logic [31:0]   rd_word;

    assign hs_fall   = hs_d & ~hs;
    assign back_sel  = ~front_sel;
    assign word_last = (32'(word) == ROW_WORDS - 1);
    assign line_bad  = (32'(line) >= TRACK_ROWS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // An hs fall during any fetch phase abandons the row; a request already
    // issued must still be retired by its ack before a new one may go out.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (hs_fall) state_next = ARM;
            ARM: begin
                if (hs_fall)       state_next = ARM;
                else if (line_bad) state_next = IDLE;
                else               state_next = REQ;
            end
            REQ:   state_next = hs_fall ? ARM : WAIT;
            WAIT: begin
                if (hs_fall)          state_next = rom.rom_ack ? ARM : DRAIN;
                else if (rom.rom_ack) state_next = word_last ? IDLE : REQ;
            end
            DRAIN: if (rom.rom_ack) state_next = ARM;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rom.rom_req = (state == WAIT) || (state == DRAIN);
        buf_we      = (state == WAIT) && rom.rom_ack && !hs_fall;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_d         <= 1'b1;
            front_sel    <= 1'b0;
            front_valid  <= 1'b0;
            back_valid   <= 1'b0;
            line_q       <= '0;
            word         <= '0;
            busy         <= 1'b0;
            underrun     <= 1'b0;
            rom.rom_addr <= '0;
        end else begin
            hs_d <= hs;
            if (state == IDLE && hs_fall && back_valid) begin
                front_sel   <= ~front_sel;
                front_valid <= 1'b1;
                back_valid  <= 1'b0;
            end
            if (state == ARM) begin
                line_q <= line;
                word   <= '0;
            end
            if (state == ARM && state_next == IDLE) back_valid <= 1'b0;
            if (state == REQ)
                rom.rom_addr <= ADDR_W'(line_q) * ADDR_W'(ROW_WORDS) + ADDR_W'(word);
            if (buf_we) begin
                if (word_last) back_valid <= 1'b1;
                else           word       <= word + 1'b1;
            end
            if (hs_fall && state != IDLE) underrun <= 1'b1;
            if (state_next == IDLE)                      busy <= 1'b0;
            else if (state == ARM && state_next == REQ)  busy <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) bank[back_sel][word] <= rom.rom_data;
    end

    // Index is clamped off-screen so the read never leaves the row.
    assign px      = DrawX[9:2];
    assign wsel    = px[7:3];
    assign nib     = px[2:0];
    assign in_view = (DrawX < 10'd640) && (32'(DrawY) < ACTIVE_ROWS) && front_valid;
    assign rd_idx  = in_view ? WW'(wsel) : '0;
    assign rd_word = bank[front_sel][rd_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pixel <= '0;
        else          pixel <= in_view ? rd_word[{nib, 2'b00} +: 4] : '0;
    end
endmodule

// File: tb/tb_track_line_fetch.sv
// Bench for track_line_fetch: ROM responder plus a row-level model of which
// track row each buffer holds, checked with immediate assertions.
module tb_track_line_fetch;
    localparam int ROW_WORDS   = 20;
    localparam int TRACK_ROWS  = 240;
    localparam int ACTIVE_ROWS = 240;
    localparam int ADDR_W      = 13;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       hs      = 1'b1;
    logic [9:0] DrawX   = '0;
    logic [9:0] DrawY   = '0;
    logic [7:0] line    = '0;
    logic [3:0] pixel;
    logic       busy;
    logic       underrun;

    track_line_fetch_if #(.ADDR_W(ADDR_W)) rom_bus ();

    track_line_fetch #(
        .ROW_WORDS(ROW_WORDS),
        .TRACK_ROWS(TRACK_ROWS),
        .ACTIVE_ROWS(ACTIVE_ROWS),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .hs(hs),
        .DrawX(DrawX),
        .DrawY(DrawY),
        .line(line),
        .rom(rom_bus),
        .pixel(pixel),
        .busy(busy),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int unsigned salt;
    bit          hold_ack = 1'b0;
    int          ack_delay = 3;
    int unsigned addr_log[$];
    int          req_cycles = 0;
    int          ack_cnt;
    int          t;

    // Row-level model: which track row each buffer holds (-1 = invalid).
    int m_front  = -1;
    int m_back   = -1;
    int m_prev   = 0;
    bit m_under  = 1'b0;
    bit m_inprog = 1'b0;

    function automatic logic [31:0] rom_word(input int unsigned a);
        return (a * 32'h9E3779B1) ^ salt ^ {a[15:0], a[15:0]};
    endfunction

    function automatic logic [3:0] exp_pixel(input int x, input int y);
        logic [31:0] w;
        int p;
        if (x >= 640 || y >= ACTIVE_ROWS || m_front < 0) return 4'd0;
        p = x / 4;
        w = rom_word(32'(m_front * ROW_WORDS + p / 8));
        return 4'(w >> (4 * (p % 8)));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ROM: acknowledges each request ack_delay cycles after it is seen.
    initial begin : rom_model
        ack_cnt = 0;
        rom_bus.rom_ack  = 1'b0;
        rom_bus.rom_data = '0;
        forever begin
            @(negedge clk);
            rom_bus.rom_ack  = 1'b0;
            rom_bus.rom_data = $urandom;
            if (rom_bus.rom_req) req_cycles++;
            if (rom_bus.rom_req && !hold_ack) begin
                ack_cnt++;
                if (ack_cnt >= ack_delay) begin
                    rom_bus.rom_ack  = 1'b1;
                    rom_bus.rom_data = rom_word(32'(rom_bus.rom_addr));
                    addr_log.push_back(32'(rom_bus.rom_addr));
                    ack_cnt = 0;
                end
            end else begin
                ack_cnt = 0;
            end
        end
    end

    task automatic do_line(input int lv, input bit hold);
        bit drain;
        int prev;
        int n_exp;
        int x;
        int y;
        @(negedge clk);
        hs    = 1'b0;
        line  = 8'(lv);
        drain = m_inprog;
        prev  = m_prev;
        if (m_inprog)        m_under = 1'b1;
        else if (m_back >= 0) m_front = m_back;
        m_back = -1;
        addr_log.delete();
        req_cycles = 0;
        if (hold) hold_ack = 1'b1;
        repeat (4) @(negedge clk);
        hs = 1'b1;
        check("busy_fetching", 32'(busy), 32'(lv < TRACK_ROWS || drain));
        check("underrun_mid", 32'(underrun), 32'(m_under));
        hold_ack = hold;
        for (int i = 0; i < 12; i++) begin
            if (i < 4)       x = i;
            else if (i < 8)  x = 632 + i;
            else if (i == 8) x = 700;
            else             x = $urandom_range(0, 639);
            y = (i == 9) ? ACTIVE_ROWS : $urandom_range(0, ACTIVE_ROWS - 1);
            DrawX = 10'(x);
            DrawY = 10'(y);
            @(negedge clk);
            check("pixel", 32'(pixel), 32'(exp_pixel(x, y)));
        end
        repeat (140) @(negedge clk);
        check("underrun_end", 32'(underrun), 32'(m_under));
        check("busy_end", 32'(busy), 32'(hold));
        check("req_end", 32'(rom_bus.rom_req), 32'(hold));
        if (hold) check("held_addr", 32'(rom_bus.rom_addr), 32'(lv * ROW_WORDS));
        if (lv >= TRACK_ROWS && !drain) check("no_req", 32'(req_cycles), 32'(0));
        n_exp = (drain ? 1 : 0) + ((!hold && lv < TRACK_ROWS) ? ROW_WORDS : 0);
        check("ack_count", 32'(addr_log.size()), 32'(n_exp));
        if (addr_log.size() == n_exp) begin
            for (int k = 0; k < n_exp; k++) begin
                if (drain && k == 0) check("addr_drained", addr_log[k], 32'(prev * ROW_WORDS));
                else check("addr", addr_log[k], 32'(lv * ROW_WORDS + k - (drain ? 1 : 0)));
            end
        end
        m_inprog = hold;
        m_prev   = lv;
        if (!hold && lv < TRACK_ROWS) m_back = lv;
    endtask

    initial begin : main
        salt = $urandom;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_pixel", 32'(pixel), 32'(0));
        check("rst_req", 32'(rom_bus.rom_req), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_underrun", 32'(underrun), 32'(0));
        check("rst_addr", 32'(rom_bus.rom_addr), 32'(0));

        ack_delay = 3;
        do_line(5, 1'b0);
        do_line(100, 1'b0);

        do_line(239, 1'b0);
        do_line(240, 1'b0);
        do_line(17, 1'b0);

        do_line(42, 1'b0);
        do_line(77, 1'b1);
        do_line(150, 1'b0);
        do_line(3, 1'b0);

        @(negedge clk);
        hs   = 1'b0;
        line = 8'd60;
        repeat (4) @(negedge clk);
        hs = 1'b1;
        t = 0;
        while (!rom_bus.rom_req && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("req_before_reset", 32'(rom_bus.rom_req), 32'(1));
        #2 reset_n = 1'b0;
        #1;
        check("async_req", 32'(rom_bus.rom_req), 32'(0));
        check("async_pixel", 32'(pixel), 32'(0));
        check("async_busy", 32'(busy), 32'(0));
        check("async_underrun", 32'(underrun), 32'(0));
        check("async_addr", 32'(rom_bus.rom_addr), 32'(0));
        repeat (3) @(negedge clk);
        reset_n  = 1'b1;
        m_front  = -1;
        m_back   = -1;
        m_under  = 1'b0;
        m_inprog = 1'b0;
        hold_ack = 1'b0;
        ack_delay = 2;
        do_line(88, 1'b0);
        do_line(120, 1'b0);
        do_line(200, 1'b0);

        for (int n = 0; n < 14; n++) begin
            int lv;
            bit hold;
            ack_delay = $urandom_range(1, 4);
            if (m_inprog || $urandom_range(0, 5) != 0) lv = $urandom_range(0, TRACK_ROWS - 1);
            else                                      lv = $urandom_range(TRACK_ROWS, 255);
            hold = !m_inprog && (lv < TRACK_ROWS) && ($urandom_range(0, 4) == 0);
            do_line(lv, hold);
        end
        if (m_inprog) do_line(9, 1'b0);
        do_line(11, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
